if_stage: RTL and testbench



---
 rtl/if_stage.sv | 158 +++++++++++++++
 tb/tb_if_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, SRAM fetch request, redirect latch.
// Optional fetch alignment check is enabled by defining FETCH_ALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'hbfc0_0000,
  parameter int          STALL_BUS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_BUS-1:0] stall,
  input  logic [32:0]          br_bus,
  output logic [32:0]          if_to_id_bus,
  output logic                 inst_sram_en,
  output logic [3:0]           inst_sram_wen,
  output logic [31:0]          inst_sram_addr,
  output logic [31:0]          inst_sram_wdata
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                 if_excp
`endif
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stop;

  logic        adv_reset;
  logic        adv_run;
  logic        capture;

  logic [31:0] seq_pc;
  logic [31:0] run_pc;
  logic [31:0] pc_nxt;
  logic        ce_nxt;
  logic        pend_v_nxt;
  logic [31:0] pend_addr_nxt;

  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign stop         = (stall[0] == STOP);
  assign unused_stall = ^stall[STALL_BUS-1:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET, S_RUN, S_HOLD: state_nxt = stop ? S_HOLD : S_RUN;
      default:                state_nxt = S_RESET;
    endcase
  end

  // The RESET exit edge only steps to RESET_PC; redirects are not honoured until RUN/HOLD.
  always_comb begin
    adv_reset = 1'b0;
    adv_run   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_RESET: adv_reset = ~stop;
      S_RUN, S_HOLD: begin
        adv_run = ~stop;
        capture = stop & br_e;
      end
      default: ;
    endcase
  end

  assign seq_pc = pc_reg + 32'd4;

  // A live branch beats the latched one; either way the latch is consumed on advance.
  always_comb begin
    run_pc = seq_pc;
    if (br_e) begin
      run_pc = br_addr;
    end else if (pend_v) begin
      run_pc = pend_addr;
    end
  end

  always_comb begin
    pc_nxt        = pc_reg;
    ce_nxt        = ce_reg;
    pend_v_nxt    = pend_v;
    pend_addr_nxt = pend_addr;
    if (adv_reset) begin
      pc_nxt = seq_pc;
      ce_nxt = 1'b1;
    end else if (adv_run) begin
      pc_nxt     = run_pc;
      ce_nxt     = 1'b1;
      pend_v_nxt = 1'b0;
    end else if (capture) begin
      pend_v_nxt    = 1'b1;
      pend_addr_nxt = br_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC - 32'd4;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'd0;
    end else begin
      pc_reg    <= pc_nxt;
      ce_reg    <= ce_nxt;
      pend_v    <= pend_v_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic excp_reg;

  // Computed from next-state values so the flag lines up with the PC it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_reg <= 1'b0;
    end else begin
      excp_reg <= ce_nxt & (pc_nxt[1:0] != 2'b00);
    end
  end

  assign if_excp      = excp_reg;
  assign inst_sram_en = ce_reg & ~excp_reg;
`else
  assign inst_sram_en = ce_reg;
`endif

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with directed redirect/stall/reset vectors.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic [32:0] br_bus = 33'd0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_excp;
`endif

  if_stage #(.RESET_PC(32'hbfc0_0000), .STALL_BUS(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .if_excp         (if_excp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        en;
    logic [31:0] pc;
    logic        x;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] RPC  = 32'hbfc0_0000;
  localparam logic [31:0] RST_PC = 32'hbfbf_fffc;

  // Inputs set here take effect at the next edge; expected values describe outputs of the current cycle.
  task automatic drive(input logic r, input logic s, input logic be, input logic [31:0] ba,
                       input logic e_ce, input logic [31:0] e_pc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    stall  = {5'b0, s};
    br_bus = {be, ba};
    e.ce = e_ce;
    e.pc = e_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    e.x  = e_ce && (e_pc[1:0] != 2'b00);
`else
    e.x  = 1'b0;
`endif
    e.en = e_ce & ~e.x;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic act_x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef FETCH_ALIGN_CHECK_EN
        act_x = if_excp;
`else
        act_x = 1'b0;
`endif
        n_cmp++;
        if (if_to_id_bus !== {e.ce, e.pc} || inst_sram_en !== e.en || inst_sram_addr !== e.pc ||
            inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'd0 || act_x !== e.x) begin
          n_bad++;
          $display("FAIL %s: got bus=%h en=%b addr=%h wen=%h wdata=%h excp=%b, want bus=%h en=%b addr=%h wen=0 wdata=0 excp=%b",
                   e.nm, if_to_id_bus, inst_sram_en, inst_sram_addr, inst_sram_wen, inst_sram_wdata, act_x,
                   {e.ce, e.pc}, e.en, e.pc, e.x);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // reset and release
    drive(1, 0, 0, 32'h0,          0, RST_PC,        "reset_held");
    drive(0, 0, 0, 32'h0,          0, RST_PC,        "reset_release");
    drive(0, 0, 0, 32'h0,          1, RPC,           "first_fetch");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0004, "seq_4");
    // taken branch at pc 0008
    drive(0, 0, 1, 32'hbfc0_0100,  1, 32'hbfc0_0008, "seq_8_branch");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0100, "branch_target");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0104, "branch_plus4");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0108, "branch_plus8");
    drive(0, 0, 1, 32'hbfc0_0010,  1, 32'hbfc0_010c, "jump_to_0010");
    // three-cycle stall with redirect in the second cycle
    drive(0, 1, 0, 32'h0,          1, 32'hbfc0_0010, "stall_enter");
    drive(0, 1, 1, 32'hbfc0_0200,  1, 32'hbfc0_0010, "stall_hold1");
    drive(0, 1, 0, 32'h0,          1, 32'hbfc0_0010, "stall_hold2");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0010, "stall_hold3");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0200, "pend_applied");
    // two redirects under stall, last one wins, applied once
    drive(0, 1, 1, 32'h0000_1000,  1, 32'hbfc0_0204, "pend_plus4");
    drive(0, 1, 1, 32'h0000_2000,  1, 32'hbfc0_0204, "two_br_hold1");
    drive(0, 1, 0, 32'h0,          1, 32'hbfc0_0204, "two_br_hold2");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0204, "two_br_hold3");
    drive(0, 0, 0, 32'h0,          1, 32'h0000_2000, "last_pend_wins");
    drive(0, 0, 0, 32'h0,          1, 32'h0000_2004, "pend_cleared");
    // live branch on stall release beats pending one
    drive(0, 1, 1, 32'h0000_3000,  1, 32'h0000_2008, "pend_3000");
    drive(0, 0, 1, 32'h0000_4000,  1, 32'h0000_2008, "release_with_br");
    drive(0, 0, 0, 32'h0,          1, 32'h0000_4000, "live_br_wins");
    // wrap around 2^32
    drive(0, 0, 1, 32'hffff_fffc,  1, 32'h0000_4004, "no_stale_pend");
    drive(0, 0, 0, 32'h0,          1, 32'hffff_fffc, "top_of_space");
    // async reset mid-stall with a pending redirect
    drive(0, 1, 1, 32'h0000_5000,  1, 32'h0000_0000, "wrap_zero");
    drive(1, 1, 0, 32'h0,          0, RST_PC,        "async_reset");
    drive(0, 0, 0, 32'h0,          0, RST_PC,        "reset_release2");
    drive(0, 0, 0, 32'h0,          1, RPC,           "first_fetch2");
    // misaligned target
    drive(0, 0, 1, 32'hbfc0_0102,  1, 32'hbfc0_0004, "pend_dropped");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0102, "misaligned");
    drive(0, 0, 1, 32'hbfc0_0200,  1, 32'hbfc0_0106, "misaligned_next");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0200, "realigned");
    drive(0, 0, 0, 32'h0,          1, 32'hbfc0_0204, "realigned_next");

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
